// File: rtl/sd_block_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sd_pkg: shared tokens, error codes and FSM states for sd_block_rx.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package sd_pkg;

  localparam logic [7:0] SD_START_TOKEN = 8'hFE;
  localparam logic [7:0] SD_FILLER      = 8'hFF;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_TIMEOUT = 2'b01,
    ERR_TOKEN   = 2'b10,
    ERR_CRC     = 2'b11
  } err_code_t;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_TOKEN = 3'd1,
    ST_DATA       = 3'd2,
    ST_CRC_HI     = 3'd3,
    ST_CRC_LO     = 3'd4,
    ST_CHECK      = 3'd5
  } rx_state_t;

  // Data error token: upper three bits clear, at least one flag bit set.
  function automatic logic is_err_token(input logic [7:0] b);
    return (b[7:5] == 3'b000) && (b != 8'h00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_block_rx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sd_block_rx_if: control, SPI byte and output stream signals.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface sd_block_rx_if;
  import sd_pkg::*;

  logic      start;
  logic      abort;
  logic      busy;
  logic      done;
  logic      error;
  err_code_t err_code;
  logic      spi_byte_req;
  logic [7:0] spi_byte_in;
  logic      spi_byte_valid;
  logic [7:0] out_data;
  logic      out_valid;
  logic      out_ready;
  logic      out_last;

  modport slave (
    input  start, abort, spi_byte_in, spi_byte_valid, out_ready,
    output busy, done, error, err_code, spi_byte_req, out_data, out_valid, out_last
  );

  modport master (
    output start, abort, spi_byte_in, spi_byte_valid, out_ready,
    input  busy, done, error, err_code, spi_byte_req, out_data, out_valid, out_last
  );

endinterface
`default_nettype wire

// File: rtl/sd_block_rx_crc16.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sd_crc16: byte-wide CRC16-CCITT (poly 0x1021, init 0), only built    |
// | with SD_BLOCK_CRC_CHECK_EN.  Revision: 1.0                            |
// +----------------------------------------------------------------------+
`ifdef SD_BLOCK_CRC_CHECK_EN
module sd_crc16 (
  input  logic        clk,
  input  logic        res_n,
  input  logic        clear_i,
  input  logic        en_i,
  input  logic [7:0]  byte_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;

  // Eight serial MSB-first steps unrolled into one cycle.
  always_comb begin
    crc_d = crc_q;
    for (int i = 7; i >= 0; i--) begin
      if (crc_d[15] ^ byte_i[i]) begin
        crc_d = {crc_d[14:0], 1'b0} ^ 16'h1021;
      end else begin
        crc_d = {crc_d[14:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      crc_q <= '0;
    end else if (clear_i) begin
      crc_q <= '0;
    end else if (en_i) begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule
`endif
`default_nettype wire

// File: rtl/sd_block_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sd_block_rx: SPI-mode SD data block receiver (token, data, CRC16).   |
// | Optional CRC verification: SD_BLOCK_CRC_CHECK_EN.  Revision: 1.0     |
// +----------------------------------------------------------------------+
module sd_block_rx
  import sd_pkg::*;
#(
  parameter int BLOCK_BYTES   = 512,
  parameter int TOKEN_TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          res_n,
  sd_block_rx_if.slave  bus
);

  localparam int CNT_W = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
  localparam int TOK_W = $clog2(TOKEN_TIMEOUT + 1);

  rx_state_t        state_q;
  err_code_t        err_q;
  logic             req_q;
  logic             pend_q;
  logic             busy_q;
  logic             done_q;
  logic             error_q;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             last_q;
  logic [CNT_W-1:0] cnt_q;
  logic [TOK_W-1:0] tok_q;

  logic byte_take;
  logic out_hs;
  logic accept;
  logic crc_match;

  // Bytes arriving without a request in flight (e.g. after abort) are dropped.
  assign byte_take = bus.spi_byte_valid && pend_q;
  assign out_hs    = valid_q && bus.out_ready;
  assign accept    = (state_q == ST_IDLE) && bus.start && !bus.abort;

`ifdef SD_BLOCK_CRC_CHECK_EN
  logic [15:0] crc_calc;
  logic [15:0] crc_rx_q;

  sd_crc16 u_crc16 (
    .clk     (clk),
    .res_n   (res_n),
    .clear_i (accept),
    .en_i    (byte_take && (state_q == ST_DATA)),
    .byte_i  (bus.spi_byte_in),
    .crc_o   (crc_calc)
  );

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      crc_rx_q <= '0;
    end else if (byte_take && (state_q == ST_CRC_HI)) begin
      crc_rx_q[15:8] <= bus.spi_byte_in;
    end else if (byte_take && (state_q == ST_CRC_LO)) begin
      crc_rx_q[7:0] <= bus.spi_byte_in;
    end
  end

  assign crc_match = (crc_calc == crc_rx_q);
`else
  assign crc_match = 1'b1;
`endif

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= ST_IDLE;
      err_q   <= ERR_NONE;
      req_q   <= 1'b0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      tok_q   <= '0;
    end else begin
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      if (bus.abort) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
        pend_q  <= 1'b0;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (bus.start) begin
              state_q <= ST_WAIT_TOKEN;
              busy_q  <= 1'b1;
              err_q   <= ERR_NONE;
              cnt_q   <= '0;
              tok_q   <= '0;
              req_q   <= 1'b1;
              pend_q  <= 1'b1;
            end
          end
          ST_WAIT_TOKEN: begin
            if (byte_take) begin
              if (bus.spi_byte_in == SD_START_TOKEN) begin
                state_q <= ST_DATA;
                req_q   <= 1'b1;
              end else if (is_err_token(bus.spi_byte_in)) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                pend_q  <= 1'b0;
                error_q <= 1'b1;
                err_q   <= ERR_TOKEN;
              end else if (tok_q == TOK_W'(TOKEN_TIMEOUT - 1)) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                pend_q  <= 1'b0;
                error_q <= 1'b1;
                err_q   <= ERR_TIMEOUT;
              end else begin
                tok_q <= tok_q + 1'b1;
                req_q <= 1'b1;
              end
            end
          end
          ST_DATA: begin
            // Request and output slot alternate, so take and handshake never coincide.
            if (byte_take) begin
              data_q  <= bus.spi_byte_in;
              valid_q <= 1'b1;
              last_q  <= (cnt_q == CNT_W'(BLOCK_BYTES - 1));
              pend_q  <= 1'b0;
            end else if (out_hs) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              req_q   <= 1'b1;
              pend_q  <= 1'b1;
              if (last_q) begin
                state_q <= ST_CRC_HI;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
          ST_CRC_HI: begin
            if (byte_take) begin
              state_q <= ST_CRC_LO;
              req_q   <= 1'b1;
            end
          end
          ST_CRC_LO: begin
            if (byte_take) begin
              state_q <= ST_CHECK;
              pend_q  <= 1'b0;
            end
          end
          ST_CHECK: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            if (crc_match) begin
              done_q <= 1'b1;
            end else begin
              error_q <= 1'b1;
              err_q   <= ERR_CRC;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            pend_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.error        = error_q;
  assign bus.err_code     = err_q;
  assign bus.spi_byte_req = req_q;
  assign bus.out_data     = data_q;
  assign bus.out_valid    = valid_q;
  assign bus.out_last     = last_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_block_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sd_block_rx: directed scoreboard bench for sd_block_rx.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_sd_block_rx;

  localparam int NB = 512;
  localparam int TT = 16;

  logic clk = 1'b0;
  logic res_n;
  always #5 clk = ~clk;

  sd_block_rx_if bus ();

  sd_block_rx #(.BLOCK_BYTES(NB), .TOKEN_TIMEOUT(TT)) dut (
    .clk   (clk),
    .res_n (res_n),
    .bus   (bus)
  );

  int compared = 0;
  int mismatched = 0;
  logic [7:0] spi_src[$];
  logic [8:0] exp_q[$];
  int req_count, outstanding, viol, hs_cnt, last_cnt, done_cnt, err_cnt, valid_cycles, resp_cd;
  bit ready_toggle;
  logic [15:0] good_crc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] block_crc();
    logic [15:0] c;
    logic [7:0]  b;
    logic        fb;
    c = 16'h0000;
    for (int i = 0; i < NB; i++) begin
      b = 8'(i);
      for (int k = 7; k >= 0; k--) begin
        fb = c[15] ^ b[k];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  // SPI engine: answers each request two negedges later.
  initial begin
    bus.spi_byte_valid = 1'b0;
    bus.spi_byte_in = 8'h00;
    resp_cd = 0;
    outstanding = 0;
    forever begin
      @(negedge clk);
      bus.spi_byte_valid = 1'b0;
      if (resp_cd > 0) begin
        resp_cd--;
        if (resp_cd == 0) begin
          if (spi_src.size() > 0) bus.spi_byte_in = spi_src.pop_front();
          else bus.spi_byte_in = 8'hFF;
          bus.spi_byte_valid = 1'b1;
          outstanding--;
        end
      end
      if (bus.spi_byte_req === 1'b1) begin
        req_count++;
        if (outstanding != 0) viol++;
        outstanding++;
        resp_cd = 2;
      end
    end
  end

  // Consumer and output monitor.
  initial begin
    logic [8:0] e;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      bus.out_ready = ready_toggle ? ~bus.out_ready : 1'b1;
      if (res_n === 1'b1) begin
        if (bus.out_valid === 1'b1) valid_cycles++;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
          hs_cnt++;
          if (bus.out_last === 1'b1) last_cnt++;
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL extra_byte: observed 0x%0h expected no byte", bus.out_data);
          end else begin
            e = exp_q.pop_front();
            check("out_last_data", {23'd0, bus.out_last, bus.out_data}, {23'd0, e});
          end
        end
        if (bus.done === 1'b1 || bus.error === 1'b1) begin
          if (bus.done === 1'b1) done_cnt++;
          if (bus.error === 1'b1) err_cnt++;
          check("done_error_exclusive", 32'(bus.done & bus.error), 0);
          check("busy_low_at_pulse", 32'(bus.busy), 0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_counts();
    req_count = 0; hs_cnt = 0; last_cnt = 0; done_cnt = 0;
    err_cnt = 0; valid_cycles = 0; viol = 0;
  endtask

  task automatic load_block(input logic [15:0] crc);
    spi_src.delete();
    exp_q.delete();
    repeat (3) spi_src.push_back(8'hFF);
    spi_src.push_back(8'hFE);
    for (int i = 0; i < NB; i++) begin
      spi_src.push_back(8'(i));
      exp_q.push_back({(i == NB - 1), 8'(i)});
    end
    spi_src.push_back(crc[15:8]);
    spi_src.push_back(crc[7:0]);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget);
    int n;
    n = 0;
    while ((done_cnt + err_cnt) == 0 && n < budget) begin
      tick(1);
      n++;
    end
    check({tag, "_completed"}, 32'((done_cnt + err_cnt) != 0), 1);
    tick(3);
  endtask

  task automatic check_good(input string tag);
    check({tag, "_done"}, done_cnt, 1);
    check({tag, "_error"}, err_cnt, 0);
    check({tag, "_err_code"}, 32'(bus.err_code), 0);
    check({tag, "_handshakes"}, hs_cnt, NB);
    check({tag, "_last_count"}, last_cnt, 1);
    check({tag, "_scoreboard_empty"}, exp_q.size(), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_requests"}, req_count, NB + 6);
    check({tag, "_one_outstanding"}, viol, 0);
  endtask

  initial begin
    int n;
    res_n = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    ready_toggle = 1'b0;
    clear_counts();
    good_crc = block_crc();
    tick(3);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_error", 32'(bus.error), 0);
    check("rst_err_code", 32'(bus.err_code), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_last", 32'(bus.out_last), 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    check("rst_spi_req", 32'(bus.spi_byte_req), 0);
    res_n = 1'b1;
    tick(2);

    // Good block, consumer always ready.
    load_block(good_crc);
    clear_counts();
    pulse_start();
    check("t1_busy_after_start", 32'(bus.busy), 1);
    wait_end("t1", 20000);
    check_good("t1");

    // Good block with toggling ready.
    ready_toggle = 1'b1;
    load_block(good_crc);
    clear_counts();
    pulse_start();
    wait_end("t2", 20000);
    check_good("t2");
    ready_toggle = 1'b0;
    tick(2);

    // Zeroed CRC bytes.
    load_block(16'h0000);
    clear_counts();
    pulse_start();
    wait_end("t3", 20000);
    check("t3_handshakes", hs_cnt, NB);
`ifdef SD_BLOCK_CRC_CHECK_EN
    check("t3_error", err_cnt, 1);
    check("t3_done", done_cnt, 0);
    check("t3_err_code", 32'(bus.err_code), 3);
`else
    check("t3_error", err_cnt, 0);
    check("t3_done", done_cnt, 1);
    check("t3_err_code", 32'(bus.err_code), 0);
`endif

    // Endless filler: token timeout.
    spi_src.delete();
    exp_q.delete();
    clear_counts();
    pulse_start();
    wait_end("t4", 2000);
    check("t4_requests", req_count, TT);
    check("t4_error", err_cnt, 1);
    check("t4_done", done_cnt, 0);
    check("t4_err_code", 32'(bus.err_code), 1);
    check("t4_busy", 32'(bus.busy), 0);
    tick(10);
    check("t4_no_more_requests", req_count, TT);

    // Data error token.
    spi_src.delete();
    spi_src.push_back(8'hFF);
    spi_src.push_back(8'h08);
    clear_counts();
    pulse_start();
    wait_end("t5", 2000);
    check("t5_requests", req_count, 2);
    check("t5_error", err_cnt, 1);
    check("t5_err_code", 32'(bus.err_code), 2);
    check("t5_no_out_valid", valid_cycles, 0);

    // start together with abort in IDLE is ignored.
    clear_counts();
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick(1);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    tick(4);
    check("t6_busy", 32'(bus.busy), 0);
    check("t6_requests", req_count, 0);
    check("t6_err_code_held", 32'(bus.err_code), 2);

    // Abort mid-block, then a fresh good block.
    load_block(good_crc);
    clear_counts();
    pulse_start();
    n = 0;
    while (hs_cnt < 100 && n < 5000) begin
      tick(1);
      n++;
    end
    check("t7_reached_100", 32'(hs_cnt >= 100), 1);
    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;
    check("t7_abort_out_valid", 32'(bus.out_valid), 0);
    check("t7_abort_busy", 32'(bus.busy), 0);
    tick(10);
    check("t7_abort_no_done", done_cnt, 0);
    check("t7_abort_no_error", err_cnt, 0);
    check("t7_abort_err_code", 32'(bus.err_code), 0);
    load_block(good_crc);
    clear_counts();
    pulse_start();
    wait_end("t7", 20000);
    check_good("t7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
